// File: rtl/iob_reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its environment.
// The clock and the asynchronous reset stay plain ports on the sequencer.
interface iob_reset_sequencer_if #(
  parameter int unsigned N_STAGES = 3
);
  logic                locked_i;
  logic                sw_rst_i;
  logic [N_STAGES-1:0] rst_o;
  logic                ready_o;
  logic [1:0]          state_o;
  logic [7:0]          lock_loss_cnt_o;

  modport slave (
    input  locked_i, sw_rst_i,
    output rst_o, ready_o, state_o, lock_loss_cnt_o
  );

  modport master (
    output locked_i, sw_rst_i,
    input  rst_o, ready_o, state_o, lock_loss_cnt_o
  );
endinterface

// File: rtl/iob_reset_sequencer.sv
// Staged release of downstream domain resets once PLL/MMCM lock has been stable;
// any lock loss or software reset request re-asserts every stage at once.
module iob_reset_sequencer #(
  parameter int unsigned N_STAGES     = 3,
  parameter int unsigned LOCK_CYCLES  = 16,
  parameter int unsigned STAGE_CYCLES = 8,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  iob_reset_sequencer_if.slave    bus
);

  localparam int unsigned STG_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(N_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STG_W-1:0]    stg_q, stg_d;
  logic [N_STAGES-1:0] rst_q, rst_d;
  logic                ready_q, ready_d;
  logic [7:0]          loss_q, loss_d;
  logic                sync1, locked_s;
  logic                abort_c;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= bus.locked_i;
      locked_s <= sync1;
    end
  end

  assign abort_c = bus.sw_rst_i | ~locked_s;

  // State and datapath registers; rst_q asserts asynchronously
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      stg_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      loss_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: if (locked_s && !bus.sw_rst_i) state_d = STABLE;
      STABLE: begin
        if (abort_c)                 state_d = WAIT_LOCK;
        else if (cnt_q == LOCK_LAST) state_d = RELEASE;
      end
      RELEASE: begin
        if (abort_c)                                           state_d = WAIT_LOCK;
        else if (cnt_q == STAGE_LAST && stg_q == LAST_STAGE)   state_d = RUN;
      end
      RUN:     if (abort_c) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Counter, stage index, reset vector and lock-loss count next values
  always_comb begin
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    loss_d  = loss_q;
    if (state_q != WAIT_LOCK && abort_c) begin
      cnt_d   = '0;
      stg_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      // Only a lock drop after release has begun counts as a loss event
      if ((state_q == RELEASE || state_q == RUN) && !locked_s && loss_q != 8'hFF)
        loss_d = loss_q + 8'd1;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          cnt_d   = '0;
          stg_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end
        STABLE: begin
          if (cnt_q == LOCK_LAST) begin
            cnt_d = '0;
            stg_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            rst_d[stg_q] = 1'b0;
            cnt_d        = '0;
            stg_d        = stg_q + STG_W'(1);
            if (stg_q == LAST_STAGE) ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          rst_d   = '0;
          ready_d = 1'b1;
        end
        default: begin
          rst_d   = '1;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.rst_o           = rst_q;
  assign bus.ready_o         = ready_q;
  assign bus.state_o         = state_q;
  assign bus.lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_iob_reset_sequencer.sv
// Directed bench for iob_reset_sequencer: every rst_o transition is matched
// against a queue of expected (cycle, rst_o, ready_o) events.
module tb_iob_reset_sequencer;

  localparam int LOCK  = 16;
  localparam int STAGE = 8;

  typedef struct {
    int       cyc;
    logic [2:0] rst;
    logic     ready;
  } ev_t;

  logic clk;
  logic arst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [2:0] prev_rst;
  ev_t  sb[$];

  iob_reset_sequencer_if #(.N_STAGES(3)) bus ();

  iob_reset_sequencer #(
    .N_STAGES(3), .LOCK_CYCLES(LOCK), .STAGE_CYCLES(STAGE), .CNT_W(8)
  ) dut (
    .clk_i (clk),
    .arst_i(arst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void push_ev(input int c, input logic [2:0] r, input logic rd);
    ev_t e;
    e.cyc = c; e.rst = r; e.ready = rd;
    sb.push_back(e);
  endfunction

  // Expected releases for a STABLE entry at edge t
  function automatic void push_release(input int t);
    push_ev(t + LOCK + 1*STAGE, 3'b110, 1'b0);
    push_ev(t + LOCK + 2*STAGE, 3'b100, 1'b0);
    push_ev(t + LOCK + 3*STAGE, 3'b000, 1'b1);
  endfunction

  // Every rst_o change pops one expected event
  always @(negedge clk) begin
    if (bus.rst_o !== prev_rst) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_rst_change: observed %0h at cycle %0d expected no change", bus.rst_o, cyc);
      end
      if (sb.size() != 0) begin
        ev_t e;
        e = sb.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_rst_ready", {bus.rst_o, bus.ready_o}, {e.rst, e.ready});
      end
    end
    prev_rst = bus.rst_o;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_timeout: observed %0d pending events expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic relock();
    int c0;
    tick();
    c0 = cyc;
    bus.locked_i = 1'b1;
    push_release(c0 + 3);
    wait_done(60);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout at cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c0, t, s;
    clk = 1'b0;
    arst = 1'b0;
    prev_rst = 3'b111;
    bus.locked_i = 1'b0;
    bus.sw_rst_i = 1'b0;
    #1 arst = 1'b1;
    tick(); tick();
    chk("reset_rst", bus.rst_o, 3'b111);
    chk("reset_ready", bus.ready_o, 1'b0);
    chk("reset_state", bus.state_o, 2'd0);
    chk("reset_cnt", bus.lock_loss_cnt_o, 8'd0);
    arst = 1'b0;
    tick(); tick();

    // Full sequence from first lock
    tick();
    c0 = cyc;
    bus.locked_i = 1'b1;
    t = c0 + 3;
    push_release(t);
    wait_cyc(t - 1);        chk("pre_stable_state", bus.state_o, 2'd0);
    wait_cyc(t);            chk("stable_entry_state", bus.state_o, 2'd1);
    wait_cyc(t + LOCK - 1); chk("stable_last_state", bus.state_o, 2'd1);
    wait_cyc(t + LOCK);     chk("release_entry_state", bus.state_o, 2'd2);
    wait_done(60);
    chk("run_state", bus.state_o, 2'd3);
    chk("run_ready", bus.ready_o, 1'b1);
    chk("run_rst", bus.rst_o, 3'b000);

    // Asynchronous reset pulse mid-RUN
    tick();
    c = cyc;
    arst = 1'b1;
    bus.locked_i = 1'b0;
    push_ev(c + 1, 3'b111, 1'b0);
    #1;
    chk("arst_rst", bus.rst_o, 3'b111);
    chk("arst_ready", bus.ready_o, 1'b0);
    chk("arst_state", bus.state_o, 2'd0);
    chk("arst_cnt", bus.lock_loss_cnt_o, 8'd0);
    tick(); tick();
    arst = 1'b0;
    wait_done(5);
    tick(); tick();
    chk("post_arst_state", bus.state_o, 2'd0);

    // One-cycle lock glitch during STABLE restarts qualification
    tick();
    c0 = cyc;
    bus.locked_i = 1'b1;
    push_release(c0 + 14);
    wait_cyc(c0 + 10); bus.locked_i = 1'b0;
    wait_cyc(c0 + 11); bus.locked_i = 1'b1;
    wait_cyc(c0 + 12); chk("glitch_pre_state", bus.state_o, 2'd1);
    wait_cyc(c0 + 13); chk("glitch_abort_state", bus.state_o, 2'd0);
    wait_cyc(c0 + 14); chk("glitch_restable_state", bus.state_o, 2'd1);
    wait_done(60);
    chk("glitch_cnt", bus.lock_loss_cnt_o, 8'd0);
    chk("glitch_run_ready", bus.ready_o, 1'b1);

    // Software reset pulse in RUN replays the sequence, no loss counted
    tick();
    s = cyc;
    bus.sw_rst_i = 1'b1;
    push_ev(s + 1, 3'b111, 1'b0);
    push_release(s + 2);
    tick();
    bus.sw_rst_i = 1'b0;
    chk("sw_abort_state", bus.state_o, 2'd0);
    chk("sw_abort_cnt", bus.lock_loss_cnt_o, 8'd0);
    wait_cyc(s + 2); chk("sw_restable_state", bus.state_o, 2'd1);
    wait_done(60);
    chk("sw_run_state", bus.state_o, 2'd3);

    // Lock drop in RELEASE after stage 0 has been released
    tick();
    s = cyc;
    bus.sw_rst_i = 1'b1;
    push_ev(s + 1, 3'b111, 1'b0);
    tick();
    bus.sw_rst_i = 1'b0;
    t = s + 2;
    push_ev(t + LOCK + STAGE, 3'b110, 1'b0);
    wait_cyc(t + LOCK + STAGE + 2);
    chk("release_mid_state", bus.state_o, 2'd2);
    c = cyc;
    bus.locked_i = 1'b0;
    push_ev(c + 3, 3'b111, 1'b0);
    wait_cyc(c + 2); chk("drop_sync_cnt", bus.lock_loss_cnt_o, 8'd0);
    wait_done(10);
    chk("drop_release_cnt", bus.lock_loss_cnt_o, 8'd1);
    chk("drop_release_state", bus.state_o, 2'd0);
    relock();
    chk("relock_ready", bus.ready_o, 1'b1);

    // Software reset coincident with the synchronized lock drop still counts
    tick();
    c = cyc;
    bus.locked_i = 1'b0;
    push_ev(c + 3, 3'b111, 1'b0);
    wait_cyc(c + 2);
    bus.sw_rst_i = 1'b1;
    tick();
    bus.sw_rst_i = 1'b0;
    chk("sw_and_drop_cnt", bus.lock_loss_cnt_o, 8'd2);
    wait_done(5);
    relock();

    // Repeated lock losses in RUN saturate the counter
    for (int i = 0; i < 258; i++) begin
      tick();
      c = cyc;
      bus.locked_i = 1'b0;
      push_ev(c + 3, 3'b111, 1'b0);
      wait_cyc(c + 3);
      chk("sat_cnt", bus.lock_loss_cnt_o, (i + 3 > 255) ? 255 : i + 3);
      relock();
    end
    chk("sat_final_cnt", bus.lock_loss_cnt_o, 8'd255);
    chk("sat_final_state", bus.state_o, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/iob_reset_sequencer.md
Name: iob_reset_sequencer

Overview:
Consumes the generated clock and its synchronized reset, plus an asynchronous PLL/MMCM lock indication. Releases a vector of downstream domain resets one stage at a time, in order, once lock has been stable for a programmable time. Any lock loss or software reset request re-asserts every stage immediately. Sits between the clock-generation wrapper and the system core, peripheral and interconnect resets.

Parameters:
N_STAGES, 3, number of sequenced reset outputs; legal range 1..8
LOCK_CYCLES, 16, consecutive synchronized-lock cycles required before release starts; must be >= 1
STAGE_CYCLES, 8, cycles between successive stage releases; must be >= 1
CNT_W, 8, width of the internal cycle counter; must satisfy 2^CNT_W > max(LOCK_CYCLES, STAGE_CYCLES)

Ports:
clk_i  input  1  system clock; all logic on its rising edge
arst_i  input  1  asynchronous active-high reset
locked_i  input  1  clock-generator lock; asynchronous to clk_i
sw_rst_i  input  1  synchronous active-high software reset request (level)
rst_o  output  N_STAGES  per-stage active-high resets; bit 0 is released first
ready_o  output  1  1 when all stages are released
state_o  output  2  current FSM state: 0 WAIT_LOCK, 1 STABLE, 2 RELEASE, 3 RUN
lock_loss_cnt_o  output  8  saturating count of lock-loss events

Behaviour:
- Reset is asynchronous and active-high on arst_i; clock is clk_i.
- On arst_i: rst_o all ones, ready_o=0, state_o=0 (WAIT_LOCK), lock_loss_cnt_o=0, counter=0, stage index=0, synchronizer flops=0. The assertion of rst_o is immediate (asynchronous).
- Lock synchronization: locked_i passes through a 2-flop synchronizer to produce locked_s. Latency is 2 edges.
- WAIT_LOCK: rst_o all ones, ready_o=0. Moves to STABLE when locked_s=1 and sw_rst_i=0; counter cleared.
- STABLE: counter increments each cycle.
  - If locked_s=0, go to WAIT_LOCK.
  - When the counter reaches LOCK_CYCLES-1, go to RELEASE with counter=0 and stage index=0.
- RELEASE: counter increments. When it reaches STAGE_CYCLES-1:
  - Register rst_o[stage]=0, then increment the stage index and clear the counter.
  - On releasing stage N_STAGES-1, go to RUN with ready_o=1 on the same edge.
- RUN: rst_o all zeros and ready_o=1. Stays in RUN until an abort condition occurs.
- Release timing: let T be the edge at which the FSM enters STABLE. Then:
  - RELEASE is entered at T+LOCK_CYCLES.
  - rst_o[k] falls at T+LOCK_CYCLES+(k+1)*STAGE_CYCLES.
  - ready_o rises together with rst_o[N_STAGES-1].
- Abort (locked_s=0 or sw_rst_i=1 while in STABLE, RELEASE or RUN): on the next edge, rst_o goes all ones, ready_o=0, state goes to WAIT_LOCK, and counter and stage index are cleared.
- sw_rst_i has priority over locked_s. While sw_rst_i=1 the FSM holds in WAIT_LOCK.
- lock_loss_cnt_o:
  - Increments by 1 on the edge where an abort is caused by locked_s=0 in RELEASE or RUN.
  - Increments even if sw_rst_i=1 in the same cycle.
  - Does not increment on a lock drop during STABLE.
  - Saturates at 255.
- Lock glitch during STABLE shorter than LOCK_CYCLES: restarts qualification with no release and no count increment.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Stage outputs release strictly in index order and are never individually re-asserted; re-assertion always covers all stages together.

Test Plan:
- arst_i pulse mid-RUN -> rst_o=3'b111, ready_o=0 and state_o=0 immediately; lock_loss_cnt_o=0.
- Defaults, locked_i rises and stays high -> STABLE entered 3 edges later (edge T); rst_o[0] falls at T+24, rst_o[1] at T+32, rst_o[2] and ready_o at T+40; state_o reads 3.
- locked_i high for 10 cycles, low for 1 cycle, then high -> no stage released, lock_loss_cnt_o stays 0; full sequence restarts from the new T.
- Drop locked_i after rst_o[0] releases (in RELEASE) -> 2 cycles of sync plus 1 edge later rst_o=3'b111, lock_loss_cnt_o=1; re-lock sequence completes normally.
- sw_rst_i pulsed 1 cycle in RUN -> next edge rst_o=3'b111, counter unchanged at 0; full sequence replays, with rst_o[0] falling at 24 edges after STABLE re-entry.
- 260 lock-loss events in RUN -> lock_loss_cnt_o saturates at 255; sw_rst_i asserted in the same cycle as a lock drop still increments the count.
